// File: rtl/vermi_uart_tx_pkg.sv
// vermi_uart_pkg: shared types and register map for the Vermibus UART transmitter
package vermi_uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam int ST_IDLE = 0;
  localparam int ST_FULL = 1;
  localparam int ST_COUNT = 8;
endpackage

// File: rtl/vermi_uart_tx_if.sv
// Vermibus: CPU data bus carrying clock, reset and a single-beat read/write handshake
interface Vermibus;
  logic clk;
  logic reset;
  logic valid;
  logic [31:0] address;
  logic [3:0] wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ready;
  logic irq;
  modport master (input clk, reset, rdata, ready, irq, output valid, address, wstrobe, wdata);
  modport read_write_response (input clk, reset, valid, address, wstrobe, wdata, output rdata, ready, irq);
endinterface

// File: rtl/vermi_uart_tx_fifo.sv
// vermififo: show-ahead synchronous FIFO with occupancy count and async reset
module vermififo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  // storage is written without reset; only pointers define validity
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vermi_uart_tx.sv
// vermi_uart_tx: Vermibus responder sending buffered bytes as 8N1 serial on txd
module vermi_uart_tx
  import vermi_uart_pkg::*;
#(
  parameter int DIVISOR = 868,
  parameter int FIFO_DEPTH = 16
) (
  Vermibus.read_write_response bus,
  output logic txd
);
  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(DIVISOR - 1);
  tx_state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] sh, fifo_q;
  logic [AW:0] count;
  logic [1:0] sel;
  logic [31:0] status;
  logic push, pop, full, empty, idle, bit_end, irq_en, unused_ok;
  assign sel = bus.address[3:2];
  assign unused_ok = ^{bus.address[31:4], bus.address[1:0], bus.wdata[31:8]};
  assign bus.ready = !(bus.valid && sel == REG_DATA && bus.wstrobe[0] && full);
  assign push = bus.valid && bus.ready && sel == REG_DATA && bus.wstrobe[0];
  assign idle = empty && state == IDLE;
  assign bit_end = baud == BAUD_MAX;
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign status = (32'(count) << ST_COUNT) | (32'(full) << ST_FULL) | (32'(idle) << ST_IDLE);
  assign bus.rdata = (sel == REG_DATA || sel == REG_STATUS) ? status :
                     sel == REG_CONTROL ? {31'b0, irq_en} : '0;
  vermififo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(bus.clk), .rst(bus.reset), .push(push), .pop(pop), .wdata(bus.wdata[7:0]),
    .rdata(fifo_q), .full(full), .empty(empty), .count(count)
  );
  // CONTROL register and the registered drain interrupt
  always_ff @(posedge bus.clk or posedge bus.reset) begin
    if (bus.reset) begin
      irq_en <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      if (bus.valid && sel == REG_CONTROL && bus.wstrobe[0]) irq_en <= bus.wdata[0];
      bus.irq <= irq_en && idle;
    end
  end
  // frame sequencer; a stop bit chains straight into the next start when data waits
  always_ff @(posedge bus.clk or posedge bus.reset) begin
    if (bus.reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      sh <= '0;
      txd <= 1'b1;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          sh <= fifo_q;
          bit_cnt <= '0;
          baud <= '0;
          txd <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          baud <= '0;
          txd <= sh[0];
          state <= DATA;
        end else baud <= baud + 1'b1;
        DATA: if (bit_end) begin
          baud <= '0;
          if (bit_cnt == 3'd7) begin
            txd <= 1'b1;
            state <= STOP;
          end else begin
            sh <= sh >> 1;
            txd <= sh[1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else baud <= baud + 1'b1;
        STOP: if (bit_end) begin
          baud <= '0;
          if (!empty) begin
            sh <= fifo_q;
            bit_cnt <= '0;
            txd <= 1'b0;
            state <= START;
          end else state <= IDLE;
        end else baud <= baud + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vermi_uart_tx.sv
// tb_vermi_uart_tx: directed self-checking bench for the Vermibus UART transmitter
module tb_vermi_uart_tx;
  localparam int DIV = 4;
  Vermibus bus();
  logic txd;
  logic cap;
  logic q[$];
  logic [7:0] bs [6];
  logic [31:0] d;
  int n_checks = 0;
  int n_fail = 0;

  vermi_uart_tx #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (.bus(bus), .txd(txd));

  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  always @(negedge bus.clk) if (cap) q.push_back(txd);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    int n = 0;
    @(negedge bus.clk);
    bus.valid = 1'b1;
    bus.address = a;
    bus.wdata = v;
    bus.wstrobe = s;
    #1;
    while (!bus.ready && n < 200) begin
      @(negedge bus.clk);
      #1;
      n++;
    end
    if (n >= 200) check("wr_timeout", 64'(bus.ready), 64'd1);
    @(posedge bus.clk);
    #1;
    bus.valid = 1'b0;
    bus.wstrobe = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge bus.clk);
    bus.valid = 1'b1;
    bus.address = a;
    bus.wstrobe = 4'h0;
    #1;
    v = bus.rdata;
    bus.valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge bus.clk);
  endtask

  task automatic check_stream(input int n);
    int s = -1;
    int zeros = 0;
    int k, idx;
    logic [39:0] got, exp;
    for (int i = 0; i < q.size(); i++) if (q[i] == 1'b0) begin
      s = i;
      break;
    end
    check("stream_start", 64'(s >= 0), 64'd1);
    if (s < 0) return;
    for (int f = 0; f < n; f++) begin
      for (int j = 0; j < 40; j++) begin
        idx = s + f * 40 + j;
        k = j / DIV;
        got[j] = idx < q.size() ? q[idx] : 1'bx;
        exp[j] = k == 0 ? 1'b0 : k == 9 ? 1'b1 : bs[f][k-1];
      end
      check($sformatf("frame%0d", f), 64'(got), 64'(exp));
    end
    for (int i = s + n * 40; i < q.size(); i++) if (q[i] == 1'b0) zeros++;
    check("stream_tail", 64'(zeros), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    int zeros = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] == 1'b0) zeros++;
    check(tag, 64'(zeros), 64'd0);
  endtask

  initial begin
    cap = 1'b0;
    bus.reset = 1'b1;
    bus.valid = 1'b0;
    bus.address = '0;
    bus.wdata = '0;
    bus.wstrobe = '0;
    cycles(3);
    @(negedge bus.clk);
    bus.reset = 1'b0;
    #1;
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_irq", 64'(bus.irq), 64'd0);
    rd(32'h4, d);
    check("rst_status", 64'(d), 64'h1);
    rd(32'h8, d);
    check("rst_control", 64'(d), 64'h0);

    wr(32'h0, 32'h77, 4'b0010);
    rd(32'h4, d);
    check("strobe0_ignored", 64'(d), 64'h1);
    wr(32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(32'hC, d);
    check("reg3_zero", 64'(d), 64'h0);
    rd(32'h0, d);
    check("data_rd_status", 64'(d), 64'h1);

    q.delete();
    cap = 1'b1;
    wr(32'h0, 32'h41, 4'h1);
    bus.address = 32'h4;
    #1;
    check("single_count1", 64'(bus.rdata), 64'h100);
    check("single_pre_start", 64'(txd), 64'd1);
    @(posedge bus.clk);
    #1;
    check("single_start_lat", 64'(txd), 64'd0);
    check("single_popped", 64'(bus.rdata), 64'h0);
    cycles(50);
    cap = 1'b0;
    bs[0] = 8'h41;
    check_stream(1);
    rd(32'h4, d);
    check("single_idle", 64'(d), 64'h1);

    q.delete();
    cap = 1'b1;
    wr(32'h0, 32'h55, 4'h1);
    wr(32'h0, 32'hAA, 4'h1);
    cycles(100);
    cap = 1'b0;
    bs[0] = 8'h55;
    bs[1] = 8'hAA;
    check_stream(2);

    q.delete();
    cap = 1'b1;
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
    for (int i = 0; i < 5; i++) wr(32'h0, 32'(bs[i]), 4'h1);
    @(negedge bus.clk);
    bus.valid = 1'b1;
    bus.address = 32'h0;
    bus.wstrobe = 4'h0;
    #1;
    check("bp_status_full", 64'(bus.rdata), 64'h402);
    check("bp_read_ready", 64'(bus.ready), 64'd1);
    bus.wdata = 32'(bs[5]);
    bus.wstrobe = 4'h1;
    #1;
    check("bp_ready_low", 64'(bus.ready), 64'd0);
    bus.valid = 1'b0;
    wr(32'h0, 32'(bs[5]), 4'h1);
    cycles(250);
    cap = 1'b0;
    check_stream(6);

    wr(32'h8, 32'h1, 4'h1);
    check("irq_not_yet", 64'(bus.irq), 64'd0);
    @(posedge bus.clk);
    #1;
    check("irq_set", 64'(bus.irq), 64'd1);
    rd(32'h8, d);
    check("control_rd", 64'(d), 64'h1);
    wr(32'h0, 32'h33, 4'h1);
    check("irq_hold_edge", 64'(bus.irq), 64'd1);
    @(posedge bus.clk);
    #1;
    check("irq_drop", 64'(bus.irq), 64'd0);
    cycles(40);
    #1;
    check("irq_still_low", 64'(bus.irq), 64'd0);
    @(posedge bus.clk);
    #1;
    check("irq_rise", 64'(bus.irq), 64'd1);
    wr(32'h8, 32'h0, 4'h1);
    @(posedge bus.clk);
    #1;
    check("irq_disabled", 64'(bus.irq), 64'd0);

    wr(32'h0, 32'hFF, 4'h1);
    wr(32'h0, 32'h00, 4'h1);
    wr(32'h0, 32'hFF, 4'h1);
    cycles(50);
    @(negedge bus.clk);
    check("mid_frame_low", 64'(txd), 64'd0);
    bus.reset = 1'b1;
    #1;
    check("async_rst_txd", 64'(txd), 64'd1);
    cycles(3);
    @(negedge bus.clk);
    bus.reset = 1'b0;
    rd(32'h4, d);
    check("post_rst_status", 64'(d), 64'h1);
    q.delete();
    cap = 1'b1;
    cycles(100);
    cap = 1'b0;
    check_quiet("post_rst_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
